// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS debug/trace observers: trace word width and
// the capture FSM state encoding exported on state_o.
package mips_dbg_pkg;

    localparam int unsigned TRACE_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with a registered read port; a word written at edge N is
// presented on rd_data/rd_valid after edge N+1 (no fall-through).
module trace_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_next;
    logic             wr_en;
    logic             empty_nx;

    always_comb begin
        full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        wr_en    = push && !full;
        rd_next  = (pop && rd_valid) ? rd_ptr + 1'b1 : rd_ptr;
        // Compared against the pre-write pointer so this cycle's write stays hidden one cycle.
        empty_nx = (rd_next == wr_ptr);
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr   <= rd_next;
            rd_valid <= !empty_nx;
            if (!empty_nx)
                rd_data <= mem[rd_next[AW-1:0]];
        end
    end

endmodule

// File: rtl/mips_trace_capture.sv
// Trace capture for the 16-bit MIPS core: arm/trigger FSM samples {pc, alu_result}
// each clock into a FIFO drained over a valid/ready stream, with drop accounting.
module mips_trace_capture
    import mips_dbg_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [15:0]        pc,
    input  logic [15:0]        alu_result,
    input  logic               arm,
    input  logic               abort,
    input  logic               trig_en,
    input  logic [15:0]        trig_pc,
    input  logic [CNT_W-1:0]   sample_limit,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TRACE_W-1:0] out_data,
    output logic [1:0]         state_o,
    output logic [CNT_W-1:0]   captured_cnt,
    output logic [CNT_W-1:0]   dropped_cnt,
    output logic               overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    trace_state_t     state;
    logic [CNT_W-1:0] attempt_cnt;
    logic [CNT_W-1:0] attempt_next;
    logic [CNT_W-1:0] captured_next;
    logic [CNT_W-1:0] dropped_next;
    logic             trigger;
    logic             attempt;
    logic             fifo_full;
    logic             push;
    logic             drop;
    logic             last;

    always_comb begin
        trigger = !trig_en || (pc == trig_pc);
        attempt = 1'b0;
        if (!abort && !arm)
            attempt = ((state == ST_ARMED) && trigger) || (state == ST_CAPTURE);
        push          = attempt && !fifo_full;
        drop          = attempt && fifo_full;
        attempt_next  = (attempt_cnt == CNT_MAX)  ? attempt_cnt  : attempt_cnt + 1'b1;
        captured_next = (captured_cnt == CNT_MAX) ? captured_cnt : captured_cnt + 1'b1;
        dropped_next  = (dropped_cnt == CNT_MAX)  ? dropped_cnt  : dropped_cnt + 1'b1;
        // Drops count as attempts, so the limit bounds the run length, not the stored count.
        last          = (sample_limit != '0) && (attempt_next == sample_limit);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            attempt_cnt  <= '0;
            captured_cnt <= '0;
            dropped_cnt  <= '0;
            overflow     <= 1'b0;
        end else if (abort) begin
            state <= ST_IDLE;
        end else if (arm) begin
            state        <= ST_ARMED;
            attempt_cnt  <= '0;
            captured_cnt <= '0;
            dropped_cnt  <= '0;
            overflow     <= 1'b0;
        end else if (attempt) begin
            attempt_cnt <= attempt_next;
            if (push)
                captured_cnt <= captured_next;
            if (drop) begin
                dropped_cnt <= dropped_next;
                overflow    <= 1'b1;
            end
            state <= last ? ST_DONE : ST_CAPTURE;
        end
    end

    assign state_o = state;

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TRACE_W)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .din      ({pc, alu_result}),
        .pop      (out_ready),
        .full     (fifo_full),
        .rd_valid (out_valid),
        .rd_data  (out_data)
    );

endmodule

// File: tb/tb_mips_trace_capture.sv
// Scoreboard bench for mips_trace_capture: a behavioural capture model queues the
// expected samples; a negedge monitor checks every presented/consumed word and status.
module tb_mips_trace_capture;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;
    localparam int CMAX  = 65535;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [15:0]      pc = '0;
    logic [15:0]      alu_result = '0;
    logic             arm = 1'b0;
    logic             abort = 1'b0;
    logic             trig_en = 1'b0;
    logic [15:0]      trig_pc = '0;
    logic [CNT_W-1:0] sample_limit = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_data;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] captured_cnt;
    logic [CNT_W-1:0] dropped_cnt;
    logic             overflow;

    always #5 clk = ~clk;

    mips_trace_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pc           (pc),
        .alu_result   (alu_result),
        .arm          (arm),
        .abort        (abort),
        .trig_en      (trig_en),
        .trig_pc      (trig_pc),
        .sample_limit (sample_limit),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .state_o      (state_o),
        .captured_cnt (captured_cnt),
        .dropped_cnt  (dropped_cnt),
        .overflow     (overflow)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: run mode (0 idle, 1 armed, 2 capturing, 3 done), counters, and
    // the ordered list of samples the consumer is owed with the cycle each was taken.
    logic [31:0] exp_q[$];
    int          take_cyc[$];
    int          occ = 0;
    int          cyc = 0;
    bit          pop_pending = 0;
    int          mst = 0;
    int          mcap = 0;
    int          mdrop = 0;
    int          matt = 0;
    bit          movf = 0;
    int          recv = 0;
    bit          got_first = 0;
    logic [15:0] first_pc = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q.delete();
            take_cyc.delete();
            occ = 0; pop_pending = 0; mst = 0;
            mcap = 0; mdrop = 0; matt = 0; movf = 0;
        end else begin
            cyc++;
            if (abort) begin
                mst = 0;
            end else if (arm) begin
                mst = 1; mcap = 0; mdrop = 0; matt = 0; movf = 0;
            end else if ((mst == 1 && (!trig_en || pc == trig_pc)) || mst == 2) begin
                if (occ < DEPTH) begin
                    exp_q.push_back({pc, alu_result});
                    take_cyc.push_back(cyc);
                    occ++;
                    if (mcap < CMAX) mcap++;
                end else begin
                    if (mdrop < CMAX) mdrop++;
                    movf = 1;
                end
                if (matt < CMAX) matt++;
                mst = (sample_limit != 0 && matt == sample_limit) ? 3 : 2;
            end
            if (pop_pending) begin
                occ--;
                pop_pending = 0;
            end
        end
    end

    always @(negedge clk) begin
        bit ev;
        ev = (exp_q.size() > 0) && (take_cyc[0] < cyc);
        chk("out_valid", out_valid, ev);
        chk("state", state_o, mst);
        chk("captured_cnt", captured_cnt, mcap);
        chk("dropped_cnt", dropped_cnt, mdrop);
        chk("overflow", overflow, movf);
        if (out_valid && ev)
            chk("out_data", out_data, exp_q[0]);
        if (out_valid && out_ready && exp_q.size() > 0) begin
            if (!got_first) begin
                first_pc  = exp_q[0][31:16];
                got_first = 1;
            end
            void'(exp_q.pop_front());
            void'(take_cyc.pop_front());
            pop_pending = 1;
            recv++;
        end
    end

    // Core stand-in: pc steps by 2 each cycle, alu_result is random; restart on request.
    int pc_req = 0;
    initial begin
        int seen;
        seen = 0;
        forever begin
            @(posedge clk);
            #1;
            if (pc_req != seen) begin
                seen = pc_req;
                pc   = '0;
            end else begin
                pc = pc + 16'd2;
            end
            alu_result = 16'($urandom);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic abort_pulse();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || occ != 0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || occ != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d samples still owed after %0d cycles", exp_q.size(), budget);
        end
    endtask

    task automatic new_run();
        recv      = 0;
        got_first = 0;
    endtask

    initial begin
        #1 $urandom(32'h1234_5678);
        #11;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_state", state_o, 0);
        chk("reset_captured", captured_cnt, 0);
        chk("reset_dropped", dropped_cnt, 0);
        chk("reset_overflow", overflow, 0);
        #1 reset_n = 1'b1;
        step();

        // 1: immediate trigger, limit 4
        new_run();
        trig_en = 0; sample_limit = 4; out_ready = 1;
        arm_pulse();
        repeat (8) step();
        chk("t1_state", state_o, 3);
        chk("t1_captured", captured_cnt, 4);
        chk("t1_dropped", dropped_cnt, 0);
        drain(40);
        chk("t1_recv", recv, 4);

        // 2: trigger on pc 0008, limit 3
        new_run();
        trig_en = 1; trig_pc = 16'h0008; sample_limit = 3;
        pc_req++;
        step();
        step();
        arm_pulse();
        repeat (15) step();
        drain(40);
        chk("t2_recv", recv, 3);
        chk("t2_first_pc", first_pc, 16'h0008);
        chk("t2_state", state_o, 3);

        // 3: consumer stalled, 20 attempts into 16 slots
        new_run();
        trig_en = 0; sample_limit = 0; out_ready = 0;
        arm_pulse();
        repeat (20) step();
        abort_pulse();
        chk("t3_captured", captured_cnt, 16);
        chk("t3_dropped", dropped_cnt, 4);
        chk("t3_overflow", overflow, 1);
        drain(60);
        chk("t3_recv", recv, 16);

        // 4: ready toggling every cycle
        new_run();
        sample_limit = 0; out_ready = 1;
        arm_pulse();
        repeat (30) begin
            out_ready = ~out_ready;
            step();
        end
        abort_pulse();
        drain(60);
        chk("t4_recv", recv, mcap);

        // 5: abort keeps FIFO contents; re-arm clears counters, old data first
        new_run();
        sample_limit = 0; out_ready = 0;
        arm_pulse();
        repeat (6) step();
        abort_pulse();
        repeat (3) step();
        chk("t5_idle", state_o, 0);
        chk("t5_kept", out_valid, 1);
        sample_limit = 5;
        arm_pulse();
        chk("t5_rearm_state", state_o, 1);
        chk("t5_rearm_captured", captured_cnt, 0);
        out_ready = 1;
        repeat (10) step();
        drain(60);
        chk("t5_recv", recv, 11);

        // 6: asynchronous reset mid-capture
        new_run();
        sample_limit = 0; out_ready = 1; trig_en = 0;
        arm_pulse();
        repeat (5) step();
        #2 reset_n = 1'b0;
        #1;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_out_data", out_data, 0);
        chk("t6_state", state_o, 0);
        chk("t6_captured", captured_cnt, 0);
        chk("t6_overflow", overflow, 0);
        #2 reset_n = 1'b1;
        repeat (3) step();
        chk("t6_after_state", state_o, 0);
        chk("t6_after_valid", out_valid, 0);

        // Random runs: random limit, trigger mode and consumer backpressure
        for (int it = 0; it < 6; it++) begin
            new_run();
            sample_limit = CNT_W'($urandom_range(0, 8));
            trig_en      = 1'($urandom_range(0, 1));
            trig_pc      = pc + 16'(2 * $urandom_range(2, 6));
            arm_pulse();
            for (int k = 0; k < 40; k++) begin
                out_ready = 1'($urandom_range(0, 1));
                step();
            end
            abort_pulse();
            drain(80);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
